rr_bank_arbiter: RTL and testbench

- Round-robin scheduler sharing one write port of a banked buffer among NUM_REQ requesters.
- Emits the winner as a binary index plus a one-hot select (1 << index), which drives bank/requester enables directly.
- Sits between PE-side requesters and the shared memory/bus write path.
- Supports bounded bursts and a valid/ready handshake to the shared resource.

---
 rtl/rr_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 40 ++++
 rtl/rr_bank_arbiter.sv | 140 ++++++++++++++
 tb/tb_rr_bank_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module  : rr_arb_pkg
// Brief   : Shared types, default constants and width helper for rr_bank_arbiter.
// Rev     : 1.0  initial release
// =============================================================================
package rr_arb_pkg;

  localparam int DEF_NUM_REQ   = 8;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_CNT_W     = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic int rr_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : rr_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// =============================================================================
// Module  : rr_pick
// Brief   : Rotating priority encoder: first set bit of (req & ~mask) at or after ptr.
// Rev     : 1.0  initial release
// =============================================================================
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = rr_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  logic [NUM_REQ-1:0] w_eff;

  assign w_eff   = i_req & ~i_mask;
  assign o_found = |w_eff;

  // Scan farthest-first so the candidate closest to i_ptr is written last and wins;
  // NUM_REQ is a power of two, so the index addition wraps for free.
  always_comb begin
    logic [IDX_W-1:0] w_pos;
    o_idx = '0;
    w_pos = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_pos = i_ptr + IDX_W'(i);
      if (w_eff[w_pos]) begin
        o_idx = w_pos;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_bank_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : rr_bank_arbiter
// Brief   : Round-robin, burst-bounded arbiter for one shared write port.
//           Define RR_ARB_STATS_EN to build the saturating grant_count counter.
// Rev     : 1.0  initial release
// =============================================================================
module rr_bank_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int IDX_W     = rr_clog2(NUM_REQ),
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ready,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic               xfer,
  output logic [CNT_W-1:0]   grant_count
);

  localparam int BURST_W = rr_clog2(MAX_BURST + 1);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [IDX_W-1:0]     r_grant_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [BURST_W-1:0]   r_burst_cnt;
  logic [BURST_W-1:0]   w_burst_nxt;

  logic                 w_valid;
  logic                 w_req_hit;
  logic                 w_xfer;
  logic                 w_last_beat;
  logic                 w_release;
  logic [IDX_W-1:0]     w_next_ptr;
  logic [IDX_W-1:0]     w_pick_ptr;
  logic [NUM_REQ-1:0]   w_pick_mask;
  logic                 w_found;
  logic [IDX_W-1:0]     w_pick_idx;

  assign w_valid     = (r_state == ST_GRANT);
  assign w_req_hit   = req[r_grant_idx];
  assign w_xfer      = w_valid & ready & w_req_hit;
  assign w_last_beat = (int'(r_burst_cnt) + 1) >= MAX_BURST;
  assign w_release   = w_valid & (~w_req_hit | (w_xfer & w_last_beat));
  assign w_next_ptr  = r_grant_idx + IDX_W'(1);

  // On release the scan restarts just past the current owner, who is masked out
  // so it cannot win twice in a row.
  assign w_pick_ptr  = w_release ? w_next_ptr : r_rr_ptr;
  assign w_pick_mask = w_release ? (NUM_REQ'(1) << r_grant_idx) : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (req),
    .i_mask  (w_pick_mask),
    .i_ptr   (w_pick_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_grant_idx;
    w_ptr_nxt   = r_rr_ptr;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_pick_idx;
          w_burst_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_ptr_nxt   = w_next_ptr;
          w_burst_nxt = '0;
          if (w_found) begin
            w_idx_nxt = w_pick_idx;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_xfer) begin
          w_burst_nxt = r_burst_cnt + BURST_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_idx_nxt;
      r_rr_ptr    <= w_ptr_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  assign grant_valid  = w_valid;
  assign grant_idx    = r_grant_idx;
  assign grant_onehot = w_valid ? (NUM_REQ'(1) << r_grant_idx) : '0;
  assign xfer         = w_xfer;

`ifdef RR_ARB_STATS_EN
  logic [CNT_W-1:0] r_grant_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant_count <= '0;
    end else if (w_xfer && (r_grant_count != {CNT_W{1'b1}})) begin
      r_grant_count <= r_grant_count + CNT_W'(1);
    end
  end

  assign grant_count = r_grant_count;
`else
  assign grant_count = '0;
`endif

endmodule : rr_bank_arbiter
`default_nettype wire

// File: tb/tb_rr_bank_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : tb_rr_bank_arbiter
// Brief   : Randomized and directed bench for rr_bank_arbiter against a rule-level model.
// Rev     : 1.0  initial release
// =============================================================================
module tb_rr_bank_arbiter;

  localparam int N  = 8;
  localparam int MB = 4;
  localparam int IW = 3;
  localparam int CW = 16;

  logic          clk   = 1'b0;
  logic          rstn  = 1'b0;
  logic [N-1:0]  req   = '0;
  logic          ready = 1'b0;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [N-1:0]  grant_onehot;
  logic          xfer;
  logic [CW-1:0] grant_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the port, where the scan restarts, beats taken, total beats.
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_beats;
  int m_count;

  always #5 clk = ~clk;

  rr_bank_arbiter #(
    .NUM_REQ   (N),
    .IDX_W     (IW),
    .MAX_BURST (MB),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req          (req),
    .ready        (ready),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .xfer         (xfer),
    .grant_count  (grant_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_pick(input logic [N-1:0] r, input int start, input int excl);
    int res;
    res = -1;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (start + k) % N;
      if (r[j] && j != excl) res = j;
    end
    return res;
  endfunction

  task automatic m_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    m_beats = 0;
    m_count = 0;
  endtask

  task automatic m_step();
    bit x;
    int w;
    x = m_valid && ready && req[m_idx];
    if (x && m_count < (1 << CW) - 1) m_count++;
    if (!m_valid) begin
      w = m_pick(req, m_ptr, -1);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_idx   = w;
        m_beats = 0;
      end
    end else if (!req[m_idx] || (x && m_beats + 1 >= MB)) begin
      m_ptr = (m_idx + 1) % N;
      w     = m_pick(req, m_ptr, m_idx);
      if (w >= 0) begin
        m_idx   = w;
        m_beats = 0;
      end else begin
        m_valid = 1'b0;
      end
    end else if (x) begin
      m_beats++;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_oh;
    logic [31:0] exp_cnt;
    exp_oh = m_valid ? (32'd1 << m_idx) : 32'd0;
`ifdef RR_ARB_STATS_EN
    exp_cnt = 32'(m_count);
`else
    exp_cnt = 32'd0;
`endif
    chk("grant_valid", 32'(grant_valid), 32'(m_valid));
    if (m_valid || !rstn) chk("grant_idx", 32'(grant_idx), 32'(m_idx));
    chk("grant_onehot", 32'(grant_onehot), exp_oh);
    chk("xfer", 32'(xfer), 32'(m_valid && ready && req[m_idx]));
    chk("grant_count", 32'(grant_count), exp_cnt);
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic rd, input logic rn);
    @(negedge clk);
    req   = r;
    ready = rd;
    rstn  = rn;
    if (!rn) m_reset();
    #1;
    check_outputs();
    @(posedge clk);
    if (!rstn) m_reset();
    else m_step();
  endtask

  task automatic async_reset_mid();
    @(negedge clk);
    #1;
    check_outputs();
    #1;
    rstn = 1'b0;
    #1;
    m_reset();
    check_outputs();
    @(posedge clk);
    m_reset();
  endtask

  initial begin
    m_reset();
    repeat (3) cycle('0, 1'b0, 1'b0);

    repeat (8) cycle(8'h01, 1'b1, 1'b1);
    repeat (3) cycle(8'h00, 1'b1, 1'b1);

    repeat (40) cycle(8'hFF, 1'b1, 1'b1);
    repeat (12) cycle(8'h81, 1'b1, 1'b1);

    repeat (10) cycle(8'h08, 1'b0, 1'b1);
    repeat (6)  cycle(8'h08, 1'b1, 1'b1);
    repeat (2)  cycle(8'h00, 1'b1, 1'b1);

    // Requester 2 withdraws before any beat while 5 is waiting.
    cycle(8'h04, 1'b0, 1'b1);
    cycle(8'h24, 1'b0, 1'b1);
    cycle(8'h20, 1'b0, 1'b1);
    repeat (5) cycle(8'h20, 1'b1, 1'b1);

    repeat (600) cycle(N'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
    repeat (200) cycle(N'($urandom | $urandom), 1'b1, 1'b1);

    cycle(8'hFF, 1'b1, 1'b0);
    repeat (7) cycle(8'hFF, 1'b1, 1'b1);
    async_reset_mid();
    cycle(8'hFF, 1'b1, 1'b0);
    repeat (12) cycle(8'hFF, 1'b1, 1'b1);
    repeat (100) cycle(N'($urandom), ($urandom_range(0, 1) != 0), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rr_bank_arbiter
`default_nettype wire
